// File: rtl/morse_signal_gen_if.sv
// Signal bundle between the tick/enable source and the Morse pattern generator.
interface morse_signal_gen_if;
  logic       tick_10ms;
  logic       enable;
  logic [2:0] word_sel;
  logic       mos_code_signal;
  logic [2:0] letter_idx;
  logic       word_done;

  modport master (
    output tick_10ms, enable, word_sel,
    input  mos_code_signal, letter_idx, word_done
  );

  modport slave (
    input  tick_10ms, enable, word_sel,
    output mos_code_signal, letter_idx, word_done
  );
endinterface

// File: rtl/morse_signal_gen.sv
// Serial Morse on/off pattern for the buzzer, spelling one of eight 5-letter words repeatedly.
// Define MORSE_RELOAD_EN to re-latch word_sel at every word-gap expiry.
module morse_signal_gen #(
  parameter int unsigned DOT_TICKS = 20
) (
  input logic               clk,
  input logic               rst,
  morse_signal_gen_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMark, StSpace, StWordGap} state_e;

  localparam logic [7:0] Unit1 = 8'(DOT_TICKS);
  localparam logic [7:0] Unit3 = 8'(3 * DOT_TICKS);
  localparam logic [7:0] Unit7 = 8'(7 * DOT_TICKS);

  // Letter code, A = 0.
  function automatic logic [4:0] word_char(input logic [2:0] w, input logic [2:0] idx);
    logic [39:0] s;
    logic [7:0]  c;
    case (w)
      3'd0: s = "SHELL";
      3'd1: s = "HALLS";
      3'd2: s = "SLICK";
      3'd3: s = "TRICK";
      3'd4: s = "BOXES";
      3'd5: s = "LEAKS";
      3'd6: s = "BRICK";
      3'd7: s = "FLICK";
    endcase
    case (idx)
      3'd0:    c = s[39:32];
      3'd1:    c = s[31:24];
      3'd2:    c = s[23:16];
      3'd3:    c = s[15:8];
      default: c = s[7:0];
    endcase
    return 5'(c - 8'h41);
  endfunction

  // {length, pattern}; pattern bit 3 is the first symbol, 1 = dash.
  function automatic logic [6:0] morse_code(input logic [4:0] ch);
    case (ch)
      5'd0:    return {3'd2, 4'b0100};  // A
      5'd1:    return {3'd4, 4'b1000};  // B
      5'd2:    return {3'd4, 4'b1010};  // C
      5'd3:    return {3'd3, 4'b1000};  // D
      5'd4:    return {3'd1, 4'b0000};  // E
      5'd5:    return {3'd4, 4'b0010};  // F
      5'd6:    return {3'd3, 4'b1100};  // G
      5'd7:    return {3'd4, 4'b0000};  // H
      5'd8:    return {3'd2, 4'b0000};  // I
      5'd9:    return {3'd4, 4'b0111};  // J
      5'd10:   return {3'd3, 4'b1010};  // K
      5'd11:   return {3'd4, 4'b0100};  // L
      5'd12:   return {3'd2, 4'b1100};  // M
      5'd13:   return {3'd2, 4'b1000};  // N
      5'd14:   return {3'd3, 4'b1110};  // O
      5'd15:   return {3'd4, 4'b0110};  // P
      5'd16:   return {3'd4, 4'b1101};  // Q
      5'd17:   return {3'd3, 4'b0100};  // R
      5'd18:   return {3'd3, 4'b0000};  // S
      5'd19:   return {3'd1, 4'b1000};  // T
      5'd20:   return {3'd3, 4'b0010};  // U
      5'd21:   return {3'd4, 4'b0001};  // V
      5'd22:   return {3'd3, 4'b0110};  // W
      5'd23:   return {3'd4, 4'b1001};  // X
      5'd24:   return {3'd4, 4'b1011};  // Y
      5'd25:   return {3'd4, 4'b1100};  // Z
      default: return {3'd1, 4'b0000};
    endcase
  endfunction

  state_e     state_q, state_d;
  logic [2:0] word_q, word_d;
  logic [2:0] letter_q, letter_d;
  logic [1:0] sym_q, sym_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mos_q, done_q, done_d;

  logic [6:0] code;
  logic       is_dash, last_sym, last_letter, expire;
  logic [7:0] dur;

  assign code        = morse_code(word_char(word_q, letter_q));
  assign is_dash     = code[2'd3 - sym_q];
  assign last_sym    = ({1'b0, sym_q} == code[6:4] - 3'd1);
  assign last_letter = (letter_q == 3'd4);
  assign expire      = bus.tick_10ms && (cnt_q == dur - 8'd1);

  always_comb begin
    dur = Unit1;
    unique case (state_q)
      StMark:    dur = is_dash ? Unit3 : Unit1;
      StSpace:   dur = last_sym ? Unit3 : Unit1;
      StWordGap: dur = Unit7;
      default:   dur = Unit1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    letter_d = letter_q;
    sym_d    = sym_q;
    done_d   = 1'b0;
    if (!bus.enable) begin
      // Dropping enable wins over any expiry in the same cycle.
      state_d  = StIdle;
      letter_d = 3'd0;
      sym_d    = 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StMark;
          word_d   = bus.word_sel;
          letter_d = 3'd0;
          sym_d    = 2'd0;
        end
        StMark: begin
          if (expire) state_d = (last_sym && last_letter) ? StWordGap : StSpace;
        end
        StSpace: begin
          if (expire) begin
            state_d = StMark;
            if (last_sym) begin
              letter_d = letter_q + 3'd1;
              sym_d    = 2'd0;
            end else begin
              sym_d = sym_q + 2'd1;
            end
          end
        end
        StWordGap: begin
          if (expire) begin
            state_d  = StMark;
            letter_d = 3'd0;
            sym_d    = 2'd0;
            done_d   = 1'b1;
`ifdef MORSE_RELOAD_EN
            word_d   = bus.word_sel;
`else
            word_d   = word_q;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (state_d != state_q || state_d == StIdle) begin
      cnt_d = 8'd0;
    end else if (bus.tick_10ms) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      word_q   <= 3'd0;
      letter_q <= 3'd0;
      sym_q    <= 2'd0;
      cnt_q    <= 8'd0;
      mos_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      letter_q <= letter_d;
      sym_q    <= sym_d;
      cnt_q    <= cnt_d;
      mos_q    <= (state_d == StMark);
      done_q   <= done_d;
    end
  end

  assign bus.mos_code_signal = mos_q;
  assign bus.letter_idx      = letter_q;
  assign bus.word_done       = done_q;

endmodule
